online_ccm_seq: RTL and testbench

Sequential, runtime-coefficient successor to the fixed-constant online CCMs. Multiplies a signed-digit (SD) operand `x` by an unsigned coefficient `coef`, which can change on every operation. It uses Horner shift-and-add over the coefficient bits with a single `online_adder` instance. It sits in the IIR datapath wherever a coefficient must be reprogrammed without resynthesis, and replaces one hard-wired CCM per constant.

---
 rtl/online_pkg.sv | 33 +++
 rtl/online_adder.sv | 38 +++
 rtl/online_ccm_seq.sv | 132 +++++++++++++
 tb/tb_online_ccm_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/online_pkg.sv
// online_pkg: shared definitions for the online (signed-digit) arithmetic blocks.
// Digit i of an SD vector occupies bits [2i+1:2i]; the plus bit is the upper one.
package online_pkg;

  localparam int PLUS_BIT  = 1;
  localparam int MINUS_BIT = 0;

  // Widest SD vector the decode helper accepts.
  localparam int SD_MAX_DIGITS = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Product digit count for an STAGE-digit operand times a CW-bit coefficient.
  function automatic int out_digits(input int stage, input int cw);
    return stage + cw + 1;
  endfunction

  // Decodes the low nd digits of an SD vector to a signed integer (bench side).
  function automatic longint sd_to_int(input logic [2*SD_MAX_DIGITS-1:0] v, input int nd);
    longint r;
    r = 0;
    for (int i = SD_MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < nd) begin
        r = r * 2 + longint'(v[2*i+PLUS_BIT]) - longint'(v[2*i+MINUS_BIT]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/online_adder.sv
// online_adder: adds two N-digit SD vectors into an (N+1)-digit SD vector.
// The plus rails and the minus rails are summed independently, so the result
// value is (Pa+Pb) - (Ma+Mb); a digit encoded 11 is a legal zero.
module online_adder
  import online_pkg::*;
#(
  parameter int N = 12
) (
  input  logic [2*N-1:0] a_i,
  input  logic [2*N-1:0] b_i,
  output logic [2*N+1:0] sum_o
);

  logic [N-1:0] a_p, a_m, b_p, b_m;
  logic [N:0]   s_p, s_m;

  // Split both operands into their plus and minus rails.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_p[i] = a_i[2*i+PLUS_BIT];
      a_m[i] = a_i[2*i+MINUS_BIT];
      b_p[i] = b_i[2*i+PLUS_BIT];
      b_m[i] = b_i[2*i+MINUS_BIT];
    end
  end

  assign s_p = {1'b0, a_p} + {1'b0, b_p};
  assign s_m = {1'b0, a_m} + {1'b0, b_m};

  // Re-interleave the rail sums into SD digit pairs.
  always_comb begin
    for (int i = 0; i <= N; i++) begin
      sum_o[2*i+PLUS_BIT]  = s_p[i];
      sum_o[2*i+MINUS_BIT] = s_m[i];
    end
  end

endmodule

// File: rtl/online_ccm_seq.sv
// online_ccm_seq: sequential SD-operand x unsigned-coefficient multiplier.
// Horner shift-and-add over coef bits (MSB first) through one online_adder.
// Optional feature: define ONLINE_CCM_SKIPZERO_EN to start at the highest set
// coefficient bit instead of CW-1 (same results, shorter latency).
//
// state | meaning
// IDLE  | waiting for start; y holds last result
// RUN   | one coefficient bit per cycle; idx counts down to 0
module online_ccm_seq
  import online_pkg::*;
#(
  parameter int STAGE = 4,
  parameter int CW    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [2*STAGE-1:0]              x,
  input  logic [CW-1:0]                   coef,
  output logic                            busy,
  output logic                            done,
  output logic [2*(STAGE+CW+1)-1:0]       y
);

  localparam int ND = STAGE + CW;
  localparam int OD = out_digits(STAGE, CW);
  localparam int IW = (CW > 1) ? $clog2(CW) : 1;

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_RUN  = RUN;

  logic [0:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d, start_idx;
  logic [2*STAGE-1:0] x_q, x_d;
  logic [CW-1:0]      coef_q, coef_d;
  logic [2*OD-1:0]    acc_q, acc_d;
  logic [2*OD-1:0]    y_q, y_d;
  logic               done_q, done_d;
  logic               accept;

  logic [2*ND-1:0]    acc_shift, addend;
  logic [2*OD-1:0]    sum;

`ifdef ONLINE_CCM_SKIPZERO_EN
  // First index is the highest set coefficient bit (0 when coef is 0).
  always_comb begin
    start_idx = '0;
    for (int i = 0; i < CW; i++) begin
      if (coef[i]) start_idx = IW'(i);
    end
  end
`else
  assign start_idx = IW'(CW - 1);
`endif

  // The top accumulator digits are zero by range, so the shift drops them.
  assign acc_shift = {acc_q[2*ND-3:0], 2'b00};
  assign addend    = coef_q[idx_q] ? {{(2*CW){1'b0}}, x_q} : '0;

  online_adder #(.N(ND)) u_adder (
    .a_i   (acc_shift),
    .b_i   (addend),
    .sum_o (sum)
  );

  // Next-state logic: accept, Horner step, completion.
  // The last RUN step also samples start so back-to-back issue costs no gap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    y_d     = y_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) accept = 1'b1;
      end
      S_RUN: begin
        acc_d = sum;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          y_d     = sum;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
          if (start) accept = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      x_d     = x;
      coef_d  = coef;
      acc_d   = '0;
      idx_d   = start_idx;
      state_d = S_RUN;
    end
  end

  // State registers; reset abandons any operation and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      coef_q  <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  // Digits discarded by the shift must be zero whenever a step is taken.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == S_RUN) |-> (acc_q[2*OD-1:2*ND-2] == '0));

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_online_ccm_seq.sv
// tb_online_ccm_seq: randomized and directed checks of online_ccm_seq against
// an integer model (y == value(x) * coef, latency from the coefficient).
module tb_online_ccm_seq;
  import online_pkg::*;

  localparam int STAGE = 4;
  localparam int CW    = 8;
  localparam int OD    = STAGE + CW + 1;

  logic                clk, rst, start, busy, done;
  logic [2*STAGE-1:0]  x;
  logic [CW-1:0]       coef;
  logic [2*OD-1:0]     y;

  int tests_run    = 0;
  int tests_failed = 0;

  online_ccm_seq #(.STAGE(STAGE), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .coef  (coef),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint yval();
    return sd_to_int(64'(y), OD);
  endfunction

  // Expected cycles from acceptance to done.
  function automatic int exp_lat(input int c);
`ifdef ONLINE_CCM_SKIPZERO_EN
    int m;
    m = 0;
    if (c == 0) return 1;
    while ((c >> (m + 1)) != 0) m++;
    return m + 1;
`else
    exp_lat = CW;
    if (c < 0) exp_lat = 0;
`endif
  endfunction

  // Issue one operation; operands are scrambled right after acceptance.
  task automatic do_op(input logic [2*STAGE-1:0] xv, input logic [CW-1:0] cv,
                       output int lat, output bit to);
    @(negedge clk);
    start = 1'b1; x = xv; coef = cv;
    @(posedge clk); #1;
    start = 1'b0;
    x = (2*STAGE)'($urandom);
    coef = CW'($urandom);
    lat = 0; to = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (lat >= 40) begin to = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int lat; bit to; bit seen;
    rst = 1'b1; start = 1'b0; x = '0; coef = '0;
    repeat (3) @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (y !== '0) begin tests_failed++; $display("FAIL reset_y got %h want 0", y); end
    @(negedge clk); rst = 1'b0;
    do_op(8'h22, 8'd74, lat, to);
    tests_run++; if (to || yval() != 370) begin tests_failed++; $display("FAIL pre_reset_y got %0d want 370 (timeout %0b)", yval(), to); end
    @(negedge clk); start = 1'b1; x = 8'h22; coef = 8'd74;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #3; rst = 1'b1; #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrun_reset_busy got %b want 0", busy); end
    tests_run++; if (yval() != 0) begin tests_failed++; $display("FAIL midrun_reset_y got %0d want 0", yval()); end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    tests_run++; if (seen || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_no_done got done_seen=%0b busy=%b want 0/0", seen, busy); end
  endtask

  task automatic test_directed();
    logic [7:0] xs[5] = '{8'h22, 8'h42, 8'hAA, 8'h55, 8'hFF};
    int         cs[5] = '{74, 74, 255, 255, 200};
    longint     es[5] = '{370, -518, 3825, -3825, 0};
    int lat; bit to;
    for (int i = 0; i < 5; i++) begin
      do_op(xs[i], CW'(cs[i]), lat, to);
      tests_run++;
      if (to || yval() != es[i]) begin
        tests_failed++; $display("FAIL directed_%0d y got %0d want %0d (timeout %0b)", i, yval(), es[i], to);
      end
      tests_run++;
      if (lat != exp_lat(cs[i])) begin
        tests_failed++; $display("FAIL directed_%0d latency got %0d want %0d", i, lat, exp_lat(cs[i]));
      end
    end
    @(posedge clk); #1;
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL done_pulse_width got %b want 0", done); end
  endtask

  task automatic test_config();
    int cs[3] = '{3, 0, 1};
    int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      do_op(8'h22, CW'(cs[i]), lat, to);
      tests_run++;
      if (to || lat != exp_lat(cs[i])) begin
        tests_failed++; $display("FAIL config_coef%0d latency got %0d want %0d", cs[i], lat, exp_lat(cs[i]));
      end
      tests_run++;
      if (yval() != 5 * cs[i]) begin
        tests_failed++; $display("FAIL config_coef%0d y got %0d want %0d", cs[i], yval(), 5 * cs[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat; bit to; int xv_int; int cv; logic [2*STAGE-1:0] xe; int r;
    for (int n = 0; n < 24; n++) begin
      xv_int = 0;
      for (int d = 0; d < STAGE; d++) begin
        r = $urandom_range(0, 3);
        case (r)
          0: xe[2*d +: 2] = 2'b00;
          1: begin xe[2*d +: 2] = 2'b10; xv_int += (1 << d); end
          2: begin xe[2*d +: 2] = 2'b01; xv_int -= (1 << d); end
          default: xe[2*d +: 2] = 2'b11;
        endcase
      end
      cv = $urandom_range(0, (1 << CW) - 1);
      do_op(xe, CW'(cv), lat, to);
      tests_run++;
      if (to || yval() != longint'(xv_int) * cv || lat != exp_lat(cv)) begin
        tests_failed++;
        $display("FAIL random_%0d x=%h coef=%0d y got %0d want %0d lat got %0d want %0d",
                 n, xe, cv, yval(), longint'(xv_int) * cv, lat, exp_lat(cv));
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat; bit to; int extra;
    @(negedge clk); start = 1'b1; x = 8'h22; coef = 8'd74;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); @(negedge clk);
    start = 1'b1; x = 8'h0A; coef = 8'd10;
    @(negedge clk); start = 1'b0;
    lat = 3; to = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      if (done) break;
      lat++;
      if (lat >= 40) begin to = 1'b1; break; end
    end
    tests_run++;
    if (to || yval() != 370 || lat != exp_lat(74)) begin
      tests_failed++; $display("FAIL ignore_start y got %0d want 370 lat got %0d want %0d", yval(), lat, exp_lat(74));
    end
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (done) extra++; end
    tests_run++;
    if (extra != 0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL ignore_start_queued got extra_done=%0d busy=%b want 0/0", extra, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat, lat2; bit to; bit held_ok;
    @(negedge clk); start = 1'b1; x = 8'h22; coef = 8'd74;
    @(posedge clk); #1;
    x = 8'h0A; coef = 8'd10;
    lat = 0; to = 1'b0;
    while (1) begin
      @(posedge clk); #1; lat++;
      if (done) break;
      if (lat >= 40) begin to = 1'b1; break; end
    end
    start = 1'b0;
    tests_run++;
    if (to || yval() != 370 || lat != exp_lat(74)) begin
      tests_failed++; $display("FAIL b2b_first y got %0d want 370 lat got %0d want %0d", yval(), lat, exp_lat(74));
    end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_accepted busy got %b want 1", busy); end
    lat2 = 0; held_ok = 1'b1; to = 1'b0;
    while (1) begin
      @(posedge clk); #1; lat2++;
      if (done) break;
      if (yval() != 370) held_ok = 1'b0;
      if (lat2 >= 40) begin to = 1'b1; break; end
    end
    tests_run++;
    if (!held_ok) begin tests_failed++; $display("FAIL b2b_y_hold got changed want 370 held"); end
    tests_run++;
    if (to || yval() != 30 || lat2 != exp_lat(10)) begin
      tests_failed++; $display("FAIL b2b_second y got %0d want 30 lat got %0d want %0d", yval(), lat2, exp_lat(10));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; coef = '0;
    test_reset();
    test_directed();
    test_config();
    test_random();
    test_ignore_start();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
